bcd_to_1of8_driver: RTL and testbench
=====================================

BCD_TO_1OF8_DRIVER -- requirements
Module: bcd_to_1of8_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter HOLD_CYCLES SHALL default to 4 and set the number of cycles a decoded one-hot code is driven; legal range is 1..255.
REQ-003 Parameter GAP_CYCLES SHALL default to 1 and set the number of all-zero cycles after each drive; legal range is 0..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in_bcd holds a code to be accepted.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 in_bcd  input  4  BCD digit; legal values are 0..7.
REQ-009 one_of_8  output  8  registered one-hot code, all-zero when not driving.
REQ-010 out_active  output  1  one_of_8 currently carries a code.
REQ-011 busy  output  1  state is not IDLE.
REQ-012 err  output  1  one-cycle pulse when an illegal code (8..15) is accepted.
REQ-013 err_count  output  8  saturating count of illegal codes accepted.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DRIVE and GAP.
REQ-015 in_ready SHALL be 1 only in IDLE and SHALL be a function of state only, with no dependence on in_valid.
REQ-016 A handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_bcd SHALL be ignored at all other times.
REQ-017 On a handshake with in_bcd<=7:
- next state SHALL be DRIVE;
- one_of_8 SHALL become 8'b1<<in_bcd on that same edge, giving one cycle of latency from handshake to output.
REQ-018 In DRIVE, one_of_8 and out_active=1 SHALL be held for exactly HOLD_CYCLES cycles.
REQ-019 At the end of DRIVE:
- if GAP_CYCLES=0, the next state SHALL be IDLE;
- otherwise the next state SHALL be GAP.
REQ-020 In GAP, one_of_8 SHALL be 8'h00 and out_active=0 for exactly GAP_CYCLES cycles; the next state SHALL then be IDLE.
REQ-021 With GAP_CYCLES=0, back-to-back codes SHALL give a one-cycle all-zero IDLE cycle between drives; in_ready is high in that cycle.
REQ-022 On a handshake with in_bcd>=8:
- the state SHALL remain IDLE;
- one_of_8 SHALL remain 8'h00;
- err SHALL be 1 for exactly the following cycle;
- err_count SHALL increment, saturating at 8'hFF.
REQ-023 one_of_8 SHALL never have more than one bit set, and SHALL be nonzero if and only if out_active=1.
REQ-024 out_active SHALL be 1 if and only if state=DRIVE.
REQ-025 busy SHALL be 1 in DRIVE and GAP.
REQ-026 The internal cycle counter SHALL be 8 bits wide and SHALL reload on every state entry.
REQ-027 Changes to in_valid or in_bcd during DRIVE or GAP SHALL have no effect.

Reset
REQ-028 While rst_n=0, the following SHALL hold asynchronously:
- state=IDLE;
- one_of_8=8'h00;
- out_active=0, busy=0, err=0;
- err_count=8'h00;
- counter=0.
REQ-029 Reset asserted mid-DRIVE or mid-GAP SHALL abort immediately; no partial drive SHALL resume after release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Defaults (HOLD=4, GAP=1), in_bcd=5 accepted at edge k -> one_of_8=8'h20 for edges k..k+3, 8'h00 at edge k+4, in_ready=1 again after edge k+5.
- Sweep in_bcd=0..7 back-to-back with in_valid held high -> one_of_8 sequence 01,02,04,...,80, each held 4 cycles, exactly one bit set.
- in_bcd=9 accepted -> err=1 for one cycle, err_count=1, one_of_8 stays 00, in_ready stays 1; 256 illegal codes -> err_count=FF (saturates).
- GAP_CYCLES=0, HOLD_CYCLES=1, codes 3 then 6 -> 08, 00, 40 on consecutive cycles.
- rst_n pulsed low during DRIVE of code 7 -> one_of_8=00 and busy=0 immediately, no residual drive after release.
- in_bcd changed from 2 to 4 during DRIVE -> one_of_8 stays 8'h04 for the full hold period.

Source files
------------

// File: rtl/bcd_to_1of8_driver.sv
// BCD digit to 1-of-8 one-hot driver with a programmable hold time and gap time.
// Codes 0..7 are driven as a one-hot pattern for HOLD_CYCLES cycles, followed by
// GAP_CYCLES all-zero cycles. Codes 8..15 are rejected with an error pulse and a
// saturating error counter.
module bcd_to_1of8_driver #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_bcd,
    output logic [7:0] one_of_8,
    output logic       out_active,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int unsigned CODE_W = 8;
    localparam int unsigned CNT_W  = 8;

    // Counter reload values: the counter counts down to zero, so load N-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? CNT_W'(0) : CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? CNT_W'(0) : CNT_W'(GAP_CYCLES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_one_of_8;
    logic                r_out_active;
    logic                r_busy;
    logic                r_in_ready;
    logic                r_err;
    logic [CNT_W-1:0]    r_err_count;

    logic                w_handshake;
    logic                w_legal;
    logic                w_cnt_done;
    logic [CODE_W-1:0]   w_code;

    // Handshake qualification and one-hot decode of the incoming digit.
    assign w_handshake = in_valid & r_in_ready;
    assign w_legal     = ~in_bcd[3];
    assign w_cnt_done  = (r_cnt == CNT_W'(0));
    assign w_code      = CODE_W'(1) << in_bcd[2:0];

    // State machine with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_W'(0);
            r_one_of_8   <= CODE_W'(0);
            r_out_active <= 1'b0;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_err        <= 1'b0;
            r_err_count  <= CNT_W'(0);
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        if (w_legal) begin
                            r_state      <= ST_DRIVE;
                            r_cnt        <= HOLD_LOAD;
                            r_one_of_8   <= w_code;
                            r_out_active <= 1'b1;
                            r_busy       <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_count != {CNT_W{1'b1}}) begin
                                r_err_count <= r_err_count + CNT_W'(1);
                            end
                        end
                    end
                end

                ST_DRIVE: begin
                    if (w_cnt_done) begin
                        r_one_of_8   <= CODE_W'(0);
                        r_out_active <= 1'b0;
                        if (HAS_GAP) begin
                            r_state <= ST_GAP;
                            r_cnt   <= GAP_LOAD;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_cnt      <= CNT_W'(0);
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (w_cnt_done) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= CNT_W'(0);
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= CNT_W'(0);
                    r_one_of_8   <= CODE_W'(0);
                    r_out_active <= 1'b0;
                    r_busy       <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign one_of_8   = r_one_of_8;
    assign out_active = r_out_active;
    assign busy       = r_busy;
    assign err        = r_err;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_bcd_to_1of8_driver.sv
// Self-checking bench for bcd_to_1of8_driver: directed vector table, hand-written
// corner sequences, and randomized traffic against a schedule-based reference model.
// Instance 0 uses HOLD=4/GAP=1, instance 1 uses HOLD=1/GAP=0.
module tb_bcd_to_1of8_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v   [2];
    logic [3:0] b   [2];
    logic       rdy [2];
    logic [7:0] o8  [2];
    logic       act [2];
    logic       bsy [2];
    logic       er  [2];
    logic [7:0] ec  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_to_1of8_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]), .in_bcd(b[0]),
        .one_of_8(o8[0]), .out_active(act[0]), .busy(bsy[0]), .err(er[0]), .err_count(ec[0])
    );

    bcd_to_1of8_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]), .in_bcd(b[1]),
        .one_of_8(o8[1]), .out_active(act[1]), .busy(bsy[1]), .err(er[1]), .err_count(ec[1])
    );

    // Reference model: each accepted legal code expands into a per-cycle schedule.
    // Entry bit 8 = busy, bits 7:0 = expected one_of_8.
    bit m_en = 1'b0;
    int sched [2][0:511];
    int slen  [2] = '{0, 0};
    int spos  [2] = '{0, 0};
    int cur   [2] = '{0, 0};
    int merr  [2] = '{0, 0};
    int mcnt  [2] = '{0, 0};

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_step(input int d);
        int h;
        int g;
        h = hold_of(d);
        g = gap_of(d);
        if (!rst_n) begin
            cur[d] = 0; slen[d] = 0; spos[d] = 0; merr[d] = 0; mcnt[d] = 0;
            return;
        end
        merr[d] = 0;
        if (cur[d] < 256 && v[d] === 1'b1) begin
            if (int'(b[d]) < 8) begin
                for (int i = 0; i < h; i++) sched[d][i] = 256 | (1 << int'(b[d]));
                for (int i = 0; i < g; i++) sched[d][h + i] = 256;
                slen[d] = h + g;
                cur[d]  = sched[d][0];
                spos[d] = 1;
            end else begin
                merr[d] = 1;
                if (mcnt[d] < 255) mcnt[d]++;
            end
        end else if (spos[d] < slen[d]) begin
            cur[d] = sched[d][spos[d]];
            spos[d]++;
        end else begin
            cur[d] = 0;
        end
    endtask

    task automatic model_check(input int d);
        int code;
        int busy_e;
        code   = cur[d] & 255;
        busy_e = (cur[d] >> 8) & 1;
        check(d == 0 ? "rand_a_one_of_8" : "rand_b_one_of_8", 32'(o8[d]), 32'(code));
        check(d == 0 ? "rand_a_active"   : "rand_b_active",   32'(act[d]), 32'(code != 0));
        check(d == 0 ? "rand_a_busy"     : "rand_b_busy",     32'(bsy[d]), 32'(busy_e));
        check(d == 0 ? "rand_a_ready"    : "rand_b_ready",    32'(rdy[d]), 32'(busy_e == 0));
        check(d == 0 ? "rand_a_err"      : "rand_b_err",      32'(er[d]),  32'(merr[d]));
        check(d == 0 ? "rand_a_err_cnt"  : "rand_b_err_cnt",  32'(ec[d]),  32'(mcnt[d]));
    endtask

    // Advance one cycle; the model follows the rising edge, checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (m_en) for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        if (m_en) for (int d = 0; d < 2; d++) model_check(d);
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(rdy[d]), 32'(1));
    endtask

    typedef struct {
        logic       v;
        logic [3:0] b;
        logic [7:0] out;
        logic       rdy;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // Defaults: code 5, ignored input while busy, illegal 9, then 2 changed to 4 mid-drive.
        tbl[0]  = '{1'b1, 4'd5, 8'h20, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'd0, 8'h20, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'd9, 8'h20, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 4'd0, 8'h20, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 4'd9, 8'h00, 1'b1, 1'b1, 8'd1};
        tbl[7]  = '{1'b0, 4'd9, 8'h00, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 4'd2, 8'h04, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 4'd4, 8'h04, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 4'd4, 8'h04, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 4'd4, 8'h04, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'd1};
        tbl[13] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'd1};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin v[d] = 1'b0; b[d] = 4'd0; end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_one_of_8", 32'(o8[d]),  32'(0));
            check("rst_busy",     32'(bsy[d]), 32'(0));
            check("rst_active",   32'(act[d]), 32'(0));
            check("rst_err",      32'(er[d]),  32'(0));
            check("rst_err_cnt",  32'(ec[d]),  32'(0));
        end
        rst_n = 1'b1;
        tick();
        check("ready_after_rst_a", 32'(rdy[0]), 32'(1));
        check("ready_after_rst_b", 32'(rdy[1]), 32'(1));

        // Vector table on the default instance.
        for (int i = 0; i < 14; i++) begin
            v[0] = tbl[i].v;
            b[0] = tbl[i].b;
            tick();
            check("tbl_one_of_8", 32'(o8[0]),  32'(tbl[i].out));
            check("tbl_active",   32'(act[0]), 32'(tbl[i].out != 8'h00));
            check("tbl_ready",    32'(rdy[0]), 32'(tbl[i].rdy));
            check("tbl_busy",     32'(bsy[0]), 32'(!tbl[i].rdy));
            check("tbl_err",      32'(er[0]),  32'(tbl[i].err));
            check("tbl_err_cnt",  32'(ec[0]),  32'(tbl[i].cnt));
        end

        // Stream illegal codes until the error counter saturates.
        v[0] = 1'b1;
        for (int i = 0; i < 260; i++) begin
            b[0] = 4'(8 + $urandom_range(0, 7));
            tick();
            check("illegal_err",   32'(er[0]),  32'(1));
            check("illegal_out",   32'(o8[0]),  32'(0));
            check("illegal_ready", 32'(rdy[0]), 32'(1));
            if (i == 253) check("illegal_cnt_ff", 32'(ec[0]), 32'(8'hFE + 8'h01));
            if (i == 252) check("illegal_cnt_fe", 32'(ec[0]), 32'(8'hFE));
        end
        check("illegal_cnt_sat", 32'(ec[0]), 32'(8'hFF));

        // Sweep 0..7 back-to-back with valid held high.
        for (int c = 0; c < 8; c++) begin
            wait_ready(0);
            b[0] = 4'(c);
            for (int h = 0; h < 4; h++) begin
                tick();
                check("sweep_code",   32'(o8[0]), 32'(1 << c));
                check("sweep_onehot", 32'($countones(o8[0])), 32'(1));
            end
            tick();
            check("sweep_gap", 32'(o8[0]), 32'(0));
        end
        v[0] = 1'b0;
        wait_ready(0);

        // HOLD=1, GAP=0: codes 3 then 6 give 08, 00, 40.
        v[1] = 1'b1; b[1] = 4'd3;
        tick();
        check("b_first", 32'(o8[1]), 32'(8'h08));
        b[1] = 4'd6;
        tick();
        check("b_idle_gap",   32'(o8[1]),  32'(8'h00));
        check("b_idle_ready", 32'(rdy[1]), 32'(1));
        tick();
        check("b_second", 32'(o8[1]), 32'(8'h40));
        v[1] = 1'b0;
        tick();
        check("b_after", 32'(o8[1]), 32'(8'h00));

        // Asynchronous reset in the middle of driving code 7.
        v[0] = 1'b1; b[0] = 4'd7;
        tick();
        check("rst_mid_pre", 32'(o8[0]), 32'(8'h80));
        v[0] = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out",  32'(o8[0]),  32'(0));
        check("rst_mid_busy", 32'(bsy[0]), 32'(0));
        check("rst_mid_cnt",  32'(ec[0]),  32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_mid_no_resume", 32'(o8[0]),  32'(0));
            check("rst_mid_ready",     32'(rdy[0]), 32'(1));
            check("rst_mid_idle",      32'(bsy[0]), 32'(0));
        end

        // Randomized traffic against the reference model, with occasional resets.
        m_en  = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            for (int d = 0; d < 2; d++) begin
                v[d] = ($urandom_range(0, 3) != 0);
                b[d] = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                   : 4'($urandom_range(0, 7));
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        m_en  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
